// File: rtl/ptp_rx_timestamp_insert_if.sv
// Byte-stream bus on the GMII receive path: 9-bit data ([8] = start-of-frame)
// plus a byte-valid strobe. The source side drives it, the sink side reads it.
interface ptp_rx_timestamp_insert_if;
    logic [8:0] pkt_data;
    logic       pkt_data_wr;

    modport master (output pkt_data, output pkt_data_wr);
    modport slave  (input  pkt_data, input  pkt_data_wr);
endinterface

// File: rtl/ptp_rx_timestamp_insert.sv
// Ingress PTP receive-timestamp writer. Samples a free-running 19-bit timer at
// frame start, classifies the frame on its ethertype (stream bytes 20-21) and,
// for PTP frames, overwrites bytes 11[2:0], 12 and 13 (low 19 bits of the dst
// MAC) as they leave a fixed-depth delay line. All other bytes pass unchanged.
module ptp_rx_timestamp_insert #(
    parameter logic [15:0] PTP_ETHERTYPE = 16'h98F7,
    parameter logic [18:0] TIMER_MAX     = 19'h7A11F,
    parameter int          DELAY         = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    ptp_rx_timestamp_insert_if.slave         rx_in,
    ptp_rx_timestamp_insert_if.master        rx_out,
    input  logic                             i_timer_rst,
    output logic                             o_stamp_pulse,
    output logic [15:0]                      ov_stamp_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_t;

    logic                    in_wr, in_sof;
    logic [7:0]              in_byte;
    logic [18:0]             timer_q, timer_d;
    logic [DELAY-1:0][9:0]   dl_q, dl_d;
    state_t                  state_q, state_d;
    logic [6:0]              cnt_q, cnt_d;
    logic [18:0]             ts_cap_q, ts_cap_d;
    logic [7:0]              b20_q, b20_d;
    logic                    in_id_q, in_id_d;
    logic                    match;
    logic [18:0]             pend_ts_q, pend_ts_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    pend_id_q, pend_id_d;
    logic [6:0]              ocnt_q, ocnt_d;
    logic                    out_id_q, out_id_d;
    logic                    stamp_pulse_q;
    logic [15:0]             stamp_cnt_q, stamp_cnt_d;
    logic [9:0]              out_word;
    logic                    out_wr, out_sof, out_id_cur, stamp_hit;
    logic [6:0]              out_idx;
    logic [8:0]              out_data;

    assign in_wr   = rx_in.pkt_data_wr;
    assign in_sof  = rx_in.pkt_data_wr & rx_in.pkt_data[8];
    assign in_byte = rx_in.pkt_data[7:0];

    // Invalid cycles enter the delay line as all-zero words so gaps are reproduced exactly.
    assign dl_d[0] = {in_wr, in_wr ? rx_in.pkt_data : 9'd0};
    generate
        for (genvar gi = 1; gi < DELAY; gi++) begin : g_dl
            assign dl_d[gi] = dl_q[gi-1];
        end
    endgenerate

    // Local timer: clear has priority over the terminal-count wrap.
    always_comb begin
        timer_d = timer_q + 19'd1;
        if (i_timer_rst || timer_q == TIMER_MAX) begin
            timer_d = 19'd0;
        end
    end

    // Input-side frame tracker: capture timestamp at SOF, classify on bytes 20-21.
    // A SOF seen in any state restarts tracking, abandoning an unclassified frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ts_cap_d = ts_cap_q;
        b20_d    = b20_q;
        in_id_d  = in_id_q;
        match    = 1'b0;
        if (in_sof) begin
            ts_cap_d = timer_q;
            cnt_d    = 7'd1;
            in_id_d  = ~in_id_q;
            state_d  = ST_HDR;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_HDR: begin
                    if (!in_wr) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
                        if (cnt_q == 7'd20) b20_d = in_byte;
                        if (cnt_q == 7'd21) begin
                            match   = ({b20_q, in_byte} == PTP_ETHERTYPE);
                            state_d = ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (!in_wr) state_d = ST_IDLE;
                    else if (cnt_q != 7'd127) cnt_d = cnt_q + 7'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Each frame carries a 1-bit id (SOF parity), counted identically on both ends
    // of the delay line, so a pending stamp is only ever applied to its own frame.
    assign out_word   = dl_q[DELAY-1];
    assign out_wr     = out_word[9];
    assign out_sof    = out_wr & out_word[8];
    assign out_idx    = out_sof ? 7'd0 : ocnt_q;
    assign out_id_cur = out_sof ? ~out_id_q : out_id_q;
    assign stamp_hit  = pend_vld_q && (pend_id_q == out_id_cur);

    // Output-side byte indexer and stamp insertion; a new match wins over a clear.
    always_comb begin
        ocnt_d     = ocnt_q;
        out_id_d   = out_id_q;
        pend_ts_d  = pend_ts_q;
        pend_vld_d = pend_vld_q;
        pend_id_d  = pend_id_q;
        out_data   = out_word[8:0];
        if (out_wr) begin
            out_id_d = out_id_cur;
            ocnt_d   = (out_idx == 7'd127) ? 7'd127 : out_idx + 7'd1;
            if (stamp_hit) begin
                case (out_idx)
                    7'd11: out_data[2:0] = pend_ts_q[18:16];
                    7'd12: out_data[7:0] = pend_ts_q[15:8];
                    7'd13: begin
                        out_data[7:0] = pend_ts_q[7:0];
                        pend_vld_d    = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (out_sof && pend_vld_q && (pend_id_q != out_id_cur)) begin
                pend_vld_d = 1'b0;
            end
        end
        if (match) begin
            pend_ts_d  = ts_cap_q;
            pend_vld_d = 1'b1;
            pend_id_d  = in_id_q;
        end
    end

    assign stamp_cnt_d = stamp_cnt_q + {15'd0, match};

    // State registers; asynchronous reset truncates any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_q       <= '0;
            dl_q          <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ts_cap_q      <= '0;
            b20_q         <= '0;
            in_id_q       <= 1'b0;
            pend_ts_q     <= '0;
            pend_vld_q    <= 1'b0;
            pend_id_q     <= 1'b0;
            ocnt_q        <= '0;
            out_id_q      <= 1'b0;
            stamp_pulse_q <= 1'b0;
            stamp_cnt_q   <= '0;
        end else begin
            timer_q       <= timer_d;
            dl_q          <= dl_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ts_cap_q      <= ts_cap_d;
            b20_q         <= b20_d;
            in_id_q       <= in_id_d;
            pend_ts_q     <= pend_ts_d;
            pend_vld_q    <= pend_vld_d;
            pend_id_q     <= pend_id_d;
            ocnt_q        <= ocnt_d;
            out_id_q      <= out_id_d;
            stamp_pulse_q <= match;
            stamp_cnt_q   <= stamp_cnt_d;
        end
    end

    assign rx_out.pkt_data    = out_data;
    assign rx_out.pkt_data_wr = out_wr;
    assign o_stamp_pulse      = stamp_pulse_q;
    assign ov_stamp_cnt       = stamp_cnt_q;
endmodule
